// File: rtl/mem_wait_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wait_arbiter: two-master memory arbiter with region wait-state sequencer |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module mem_wait_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_active,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  input  logic              m2_read,
  input  logic              m2_write,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [DATA_W-1:0] m2_wdata,
  output logic [DATA_W-1:0] m2_rdata,
  output logic              m2_ready,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ext_ready,
  input  logic [CNT_W-1:0]  cfg_sram_ws,
  input  logic [CNT_W-1:0]  cfg_io_ws,
  input  logic [CNT_W-1:0]  cfg_ext_ws,
  output logic [1:0]        grant,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner_m2;
  logic              r_rr_last_m2;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic              r_ext;
  logic [CNT_W-1:0]  r_ws;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;
  logic [DATA_W-1:0] r_m1_rdata;
  logic [DATA_W-1:0] r_m2_rdata;

  logic              w_m1_req;
  logic              w_m2_req;
  logic              w_start;
  logic              w_pick_m2;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_write;
  logic              w_sel_io;
  logic              w_sel_sram;
  logic [CNT_W-1:0]  w_sel_ws;
  logic              w_done_int;
  logic              w_done_ext;
  logic              w_done_to;
  logic              w_complete;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_access;
  logic              w_done;

  // M1 wins only on boot priority or when M2 was served last.
  assign w_m1_req    = m1_read | m1_write;
  assign w_m2_req    = m2_read | m2_write;
  assign w_start     = w_m1_req | w_m2_req;
  assign w_pick_m2   = w_m2_req && (!w_m1_req || (!boot_active && !r_rr_last_m2));
  assign w_sel_addr  = w_pick_m2 ? m2_addr  : m1_addr;
  assign w_sel_wdata = w_pick_m2 ? m2_wdata : m1_wdata;
  assign w_sel_write = w_pick_m2 ? m2_write : m1_write;

  assign w_sel_io   = (w_sel_addr[31:20] == 12'h1A1) && (w_sel_addr[19:17] == 3'b000);
  assign w_sel_sram = (w_sel_addr[31:12] == 20'h00000);
  assign w_sel_ws   = w_sel_io ? cfg_io_ws : (w_sel_sram ? cfg_sram_ws : cfg_ext_ws);

  // External ready takes precedence over a timeout landing in the same cycle.
  assign w_done_int = !r_ext && (r_cnt == r_ws);
  assign w_done_ext = r_ext && s_ext_ready;
  assign w_done_to  = r_ext && !s_ext_ready && (r_cnt == c_timeout);
  assign w_complete = w_done_int | w_done_ext | w_done_to;
  assign w_cap_data = r_write ? '0 : (w_done_to ? '1 : s_rdata);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start)    w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_complete) w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner_m2   <= 1'b0;
      r_rr_last_m2 <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_ext        <= 1'b0;
      r_ws         <= '0;
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
      r_m1_rdata   <= '0;
      r_m2_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_owner_m2   <= w_pick_m2;
            r_rr_last_m2 <= w_pick_m2;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_write      <= w_sel_write;
            r_ext        <= !w_sel_io && !w_sel_sram;
            r_ws         <= w_sel_ws;
            r_cnt        <= '0;
          end
        end
        ST_ACCESS: begin
          if (w_complete) begin
            r_timeout <= w_done_to;
            if (r_owner_m2) r_m2_rdata <= w_cap_data;
            else            r_m1_rdata <= w_cap_data;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_done   = (r_state == ST_DONE);

  assign s_read   = w_access & ~r_write;
  assign s_write  = w_access &  r_write;
  assign s_addr   = w_access ? r_addr  : '0;
  assign s_wdata  = w_access ? r_wdata : '0;
  assign grant    = w_access ? {r_owner_m2, ~r_owner_m2} : 2'b00;
  assign m1_ready = w_done & ~r_owner_m2;
  assign m2_ready = w_done &  r_owner_m2;
  assign m1_rdata = r_m1_rdata;
  assign m2_rdata = r_m2_rdata;
  assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_wait_arbiter: scoreboard bench for the two-master wait-state arbiter  |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_wait_arbiter;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_active;
  logic        m1_read, m1_write, m2_read, m2_write;
  logic [31:0] m1_addr, m2_addr;
  logic [7:0]  m1_wdata, m2_wdata, m1_rdata, m2_rdata;
  logic        m1_ready, m2_ready;
  logic        s_read, s_write;
  logic [31:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;
  logic        s_ext_ready;
  logic [7:0]  cfg_sram_ws, cfg_io_ws, cfg_ext_ws;
  logic [1:0]  grant;
  logic        timeout;

  mem_wait_arbiter #(.ADDR_W(32), .DATA_W(8), .CNT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .boot_active(boot_active),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .m2_read(m2_read), .m2_write(m2_write), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
    .m2_rdata(m2_rdata), .m2_ready(m2_ready),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ext_ready(s_ext_ready),
    .cfg_sram_ws(cfg_sram_ws), .cfg_io_ws(cfg_io_ws), .cfg_ext_ws(cfg_ext_ws),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       m2;
    bit [7:0] data;
    bit       to;
  } exp_t;

  exp_t     sb_q[$];
  int       n_pass = 0;
  int       n_total = 0;
  bit [7:0] mdl1 = 8'h00;
  bit [7:0] mdl2 = 8'h00;

  // Bus observations gathered by run_bus for the scenario tasks.
  int          n_rd, n_wr, first_rdy;
  logic [1:0]  grant_seen;
  logic [7:0]  w_first_data;
  logic [31:0] w_first_addr;
  bit          w_stable;

  // Plays both masters (drop strobes on ready) and drains the scoreboard.
  task automatic run_bus(input int budget, input int ext_at, input bit chg_cfg);
    int   acc;
    bit   fin;
    exp_t e;
    logic [1:0] got_own, exp_own;
    logic [7:0] got_d, oth, exp_oth;
    acc = 0; fin = 0; n_rd = 0; n_wr = 0; first_rdy = 0;
    grant_seen = 2'b00; w_stable = 1; w_first_data = 8'h00; w_first_addr = 32'h0;
    for (int c = 1; c <= budget && !fin; c++) begin
      @(negedge clk);
      grant_seen = grant_seen | grant;
      if (grant != 2'b00) acc++;
      if (s_read) n_rd++;
      if (s_write) begin
        n_wr++;
        if (n_wr == 1) begin w_first_data = s_wdata; w_first_addr = s_addr; end
        else if (s_wdata !== w_first_data || s_addr !== w_first_addr) w_stable = 0;
      end
      if (chg_cfg && acc == 2) cfg_io_ws = 8'd1;
      if (ext_at != 0 && acc == ext_at && grant != 2'b00) s_ext_ready = 1'b1;
      if (m1_ready || m2_ready) begin
        if (first_rdy == 0) first_rdy = c;
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_ready: got ready=%b%b, expected no completion", m2_ready, m1_ready);
        end else begin
          e = sb_q.pop_front();
          got_own = {m2_ready, m1_ready};
          exp_own = e.m2 ? 2'b10 : 2'b01;
          got_d   = e.m2 ? m2_rdata : m1_rdata;
          oth     = e.m2 ? m1_rdata : m2_rdata;
          exp_oth = e.m2 ? mdl1 : mdl2;
          if (got_own !== exp_own || got_d !== e.data || timeout !== e.to || oth !== exp_oth)
            $display("FAIL sb_completion: got ready=%b rdata=%h timeout=%b other=%h, expected ready=%b rdata=%h timeout=%b other=%h",
                     got_own, got_d, timeout, oth, exp_own, e.data, e.to, exp_oth);
          else n_pass++;
          if (e.m2) mdl2 = e.data; else mdl1 = e.data;
        end
        if (m1_ready) begin m1_read = 0; m1_write = 0; end
        if (m2_ready) begin m2_read = 0; m2_write = 0; end
        s_ext_ready = 1'b0;
      end else if (timeout) begin
        n_total++;
        $display("FAIL timeout_alone: got timeout=1 without ready, expected 0");
      end
      if (!(m1_read | m1_write | m2_read | m2_write) && grant == 2'b00) fin = 1;
    end
    if (!fin) begin
      n_total++;
      $display("FAIL bus_budget: got no idle within %0d cycles, expected idle", budget);
      m1_read = 0; m1_write = 0; m2_read = 0; m2_write = 0; s_ext_ready = 0;
    end
    @(negedge clk);
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 0; boot_active = 0;
    m1_read = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0;
    m2_read = 0; m2_write = 0; m2_addr = 0; m2_wdata = 0;
    s_rdata = 0; s_ext_ready = 0;
    cfg_sram_ws = 0; cfg_io_ws = 0; cfg_ext_ws = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({grant, s_read, s_write, m1_ready, m2_ready, timeout} !== 7'b0 || s_addr !== 32'h0 || s_wdata !== 8'h0)
      $display("FAIL reset_outputs: got grant=%b rd=%b wr=%b rdy=%b%b to=%b addr=%h, expected all 0",
               grant, s_read, s_write, m2_ready, m1_ready, timeout, s_addr);
    else n_pass++;
    rst = 1;
    @(negedge clk);
    n_total++;
    if (grant !== 2'b00 || m1_rdata !== 8'h0 || m2_rdata !== 8'h0)
      $display("FAIL reset_idle: got grant=%b m1_rdata=%h m2_rdata=%h, expected 00/00/00", grant, m1_rdata, m2_rdata);
    else n_pass++;
  endtask

  task automatic test_sram_read();
    cfg_sram_ws = 8'd3; s_rdata = 8'hA5;
    m2_addr = 32'h0000_0010; m2_read = 1;
    sb_q.push_back('{m2: 1'b1, data: 8'hA5, to: 1'b0});
    run_bus(50, 0, 0);
    n_total++;
    if (n_rd !== 4) $display("FAIL sram_sread_cycles: got %0d, expected 4", n_rd); else n_pass++;
    n_total++;
    if (first_rdy !== 5) $display("FAIL sram_latency: got %0d, expected 5", first_rdy); else n_pass++;
    n_total++;
    if (grant_seen !== 2'b10 || grant !== 2'b00)
      $display("FAIL sram_grant: got seen=%b now=%b, expected 10/00", grant_seen, grant);
    else n_pass++;
  endtask

  task automatic test_priority();
    cfg_sram_ws = 8'd0;
    m1_addr = 32'h0000_0100; m1_wdata = 8'h11;
    m2_addr = 32'h0000_0200; m2_wdata = 8'h22;
    // Boot priority, then round robin from rr_last=M2, then from rr_last=M1.
    for (int k = 0; k < 2; k++) begin
      boot_active = (k == 0);
      m1_write = 1; m2_write = 1;
      sb_q.push_back('{m2: 1'b0, data: 8'h00, to: 1'b0});
      sb_q.push_back('{m2: 1'b1, data: 8'h00, to: 1'b0});
      run_bus(50, 0, 0);
      n_total++;
      if (n_wr !== 2) $display("FAIL prio_writes_%0d: got %0d, expected 2", k, n_wr); else n_pass++;
    end
    boot_active = 0;
    m1_write = 1;
    sb_q.push_back('{m2: 1'b0, data: 8'h00, to: 1'b0});
    run_bus(50, 0, 0);
    m1_write = 1; m2_write = 1;
    sb_q.push_back('{m2: 1'b1, data: 8'h00, to: 1'b0});
    sb_q.push_back('{m2: 1'b0, data: 8'h00, to: 1'b0});
    run_bus(50, 0, 0);
  endtask

  task automatic test_ext_ready();
    s_rdata = 8'h3C;
    m2_addr = 32'h2000_0000; m2_read = 1;
    sb_q.push_back('{m2: 1'b1, data: 8'h3C, to: 1'b0});
    run_bus(100, 6, 0);
    n_total++;
    if (n_rd !== 6) $display("FAIL ext_cycles: got %0d, expected 6", n_rd); else n_pass++;
    n_total++;
    if (first_rdy !== 7) $display("FAIL ext_latency: got %0d, expected 7", first_rdy); else n_pass++;
  endtask

  task automatic test_timeout();
    s_rdata = 8'h12;
    m2_addr = 32'h2000_0000; m2_read = 1;
    sb_q.push_back('{m2: 1'b1, data: 8'hFF, to: 1'b1});
    run_bus(400, 0, 0);
    n_total++;
    if (n_rd !== TO + 1) $display("FAIL to_cycles: got %0d, expected %0d", n_rd, TO + 1); else n_pass++;
    n_total++;
    if (first_rdy !== TO + 2) $display("FAIL to_latency: got %0d, expected %0d", first_rdy, TO + 2); else n_pass++;
  endtask

  task automatic test_io_write();
    cfg_io_ws = 8'd5;
    m1_addr = 32'h1A10_FFE0; m1_wdata = 8'h41; m1_write = 1;
    sb_q.push_back('{m2: 1'b0, data: 8'h00, to: 1'b0});
    run_bus(50, 0, 1);
    n_total++;
    if (n_wr !== 6) $display("FAIL io_write_cycles: got %0d, expected 6", n_wr); else n_pass++;
    n_total++;
    if (w_first_data !== 8'h41 || w_first_addr !== 32'h1A10_FFE0 || !w_stable)
      $display("FAIL io_write_bus: got data=%h addr=%h stable=%0b, expected 41/1a10ffe0/1",
               w_first_data, w_first_addr, w_stable);
    else n_pass++;
    cfg_io_ws = 8'd0;
  endtask

  task automatic test_write_wins();
    cfg_sram_ws = 8'd1;
    m2_addr = 32'h0000_0020; m2_wdata = 8'h5A; m2_read = 1; m2_write = 1;
    sb_q.push_back('{m2: 1'b1, data: 8'h00, to: 1'b0});
    run_bus(50, 0, 0);
    n_total++;
    if (n_wr !== 2 || n_rd !== 0 || w_first_data !== 8'h5A)
      $display("FAIL write_wins: got wr=%0d rd=%0d data=%h, expected 2/0/5a", n_wr, n_rd, w_first_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    m2_addr = 32'h2000_0000; m2_read = 1;
    repeat (4) @(negedge clk);
    m1_addr = 32'h0000_0030; m1_read = 1;
    #2 rst = 0;
    #1;
    n_total++;
    if ({grant, s_read, s_write, m1_ready, m2_ready, timeout} !== 7'b0 || s_addr !== 32'h0 ||
        m1_rdata !== 8'h0 || m2_rdata !== 8'h0)
      $display("FAIL rst_mid_outputs: got grant=%b rd=%b wr=%b rdy=%b%b addr=%h rdata=%h/%h, expected all 0",
               grant, s_read, s_write, m2_ready, m1_ready, s_addr, m1_rdata, m2_rdata);
    else n_pass++;
    mdl1 = 8'h00; mdl2 = 8'h00;
    m2_read = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_total++;
    if (grant !== 2'b01) $display("FAIL rst_mid_regrant: got %b, expected 01", grant); else n_pass++;
    s_rdata = 8'h77;
    sb_q.push_back('{m2: 1'b0, data: 8'h77, to: 1'b0});
    run_bus(50, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_priority();
    test_ext_ready();
    test_timeout();
    test_io_write();
    test_write_wins();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
